// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 3;
  localparam int CNT_W          = 4;
  localparam int STARVE_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_src_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Memory latency countdown: load, saturating decrement, zero flag.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a load wins over a decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter_core.sv
// Arbiter FSM: grants one access at a time to the unified memory,
// prefers data accesses but forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter_core
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  gnt_src_e            gnt_src_q, gnt_src_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic force_fetch, grant_data, grant_fetch;

  // Data has priority unless fetch has waited STARVE_MAX data grants.
  assign force_fetch = bus.if_req && bus.dm_req && (starve_q == STARVE_LIM);
  assign grant_data  = bus.dm_req && !force_fetch;
  assign grant_fetch = bus.if_req && !grant_data;

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // Next-state, grant, capture and ready-pulse logic.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    gnt_src_d   = gnt_src_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_data || grant_fetch) begin
          state_d  = ST_BUSY;
          cnt_load = 1'b1;
          mem_en_d = 1'b1;
          if (grant_data) begin
            gnt_src_d   = GNT_DATA;
            mem_addr_d  = bus.dm_addr;
            mem_we_d    = bus.dm_we;
            mem_wdata_d = bus.dm_wdata;
            starve_d    = bus.if_req ? (starve_q + STARVE_W'(1)) : '0;
          end else begin
            gnt_src_d   = GNT_FETCH;
            mem_addr_d  = bus.if_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d  = ST_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_src_q == GNT_DATA) begin
            dm_ready_d = 1'b1;
            // A store leaves the previous load data in place.
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      // No grant here, so a requester dropping req after ready is not re-served.
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      gnt_src_q   <= GNT_FETCH;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      gnt_src_q   <= gnt_src_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ready_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Top level: flat pipeline/memory ports bundled into the arbiter interface.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  mem_port_arbiter_if bus ();

  assign bus.if_req    = if_req;
  assign bus.if_addr   = if_addr;
  assign bus.dm_req    = dm_req;
  assign bus.dm_we     = dm_we;
  assign bus.dm_addr   = dm_addr;
  assign bus.dm_wdata  = dm_wdata;
  assign bus.mem_rdata = mem_rdata;

  assign if_rdata  = bus.if_rdata;
  assign if_ready  = bus.if_ready;
  assign dm_rdata  = bus.dm_rdata;
  assign dm_ready  = bus.dm_ready;
  assign mem_en    = bus.mem_en;
  assign mem_we    = bus.mem_we;
  assign mem_addr  = bus.mem_addr;
  assign mem_wdata = bus.mem_wdata;
  assign stall_if  = bus.stall_if;
  assign stall_mem = bus.stall_mem;

  mem_port_arbiter_core #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: MEM_LAT, default 2, memory access latency in cycles (legal 1..15); STARVE_MAX, default 3, maximum consecutive data grants while a fetch waits (legal 1..7).
REQ-002 Ports SHALL be, in order:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- if_req, in, 1: instruction-fetch request.
- if_addr, in, 32: fetch address (pc).
- if_rdata, out, 32: fetched instruction.
- if_ready, out, 1: fetch complete.
- dm_req, in, 1: data-stage request.
- dm_we, in, 1: 1 = store, 0 = load.
- dm_addr, in, 32: data address.
- dm_wdata, in, 32: store data.
- dm_rdata, out, 32: load data.
- dm_ready, out, 1: data access complete.
- mem_en, out, 1: memory port enable.
- mem_we, out, 1: memory write enable.
- mem_addr, out, 32: memory address.
- mem_wdata, out, 32: memory write data.
- mem_rdata, in, 32: memory read data.
- stall_if, out, 1: hold PC and the IF/ID register.
- stall_mem, out, 1: freeze the pipeline at the MEM stage.
REQ-003 The clock SHALL be one clock, clk; the reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 The block SHALL share one single-ported unified memory between the fetch and data stages; only one access SHALL be in flight at a time.
REQ-005 The FSM SHALL have states IDLE, BUSY and RESP.
- IDLE -> BUSY on a grant.
- BUSY -> RESP when the latency counter is 0.
- RESP -> IDLE unconditionally.
REQ-006 Grants SHALL be made only in IDLE. The grant goes to the data stage when dm_req=1, else to fetch when if_req=1.
REQ-007 Exception to REQ-006: when both requests are high and starve_cnt equals STARVE_MAX, fetch SHALL be granted.
REQ-008 starve_cnt (3 bits) SHALL update on each grant:
- +1 on a data grant while if_req=1;
- cleared on a fetch grant;
- cleared on a data grant while if_req=0.
REQ-009 On the grant edge:
- mem_addr, mem_we and mem_wdata SHALL be registered from the granted requester;
- mem_we SHALL be 0 for fetch;
- the counter SHALL load MEM_LAT-1;
- gnt_src (0 = fetch, 1 = data) SHALL be latched.
REQ-010 mem_en SHALL be 1 exactly during BUSY cycles, so it is high for MEM_LAT cycles per access. mem_addr, mem_we and mem_wdata SHALL be stable throughout BUSY.
REQ-011 The counter SHALL decrement once per BUSY cycle and SHALL never wrap.
REQ-012 On the BUSY->RESP edge, mem_rdata SHALL be captured:
- into if_rdata for a fetch;
- into dm_rdata for a data load;
- for a store, dm_rdata SHALL hold its previous value.
REQ-013 if_ready or dm_ready (per gnt_src) SHALL be 1 for exactly the single RESP cycle. The rdata output SHALL be valid in that cycle and SHALL hold until the next capture.
REQ-014 Timing: with a request sampled at edge k and the arbiter idle, ready SHALL be high in the cycle after edge k+MEM_LAT. Sustained throughput SHALL be one access per MEM_LAT+2 cycles.
REQ-015 The RESP state SHALL perform no grant, so a requester that drops its request after seeing ready is never re-granted.
REQ-016 Requesters SHALL hold req, addr, we and wdata stable until their ready. If a req is withdrawn mid-access, the access SHALL still complete and ready SHALL still pulse.
REQ-017 Stalls SHALL be combinational: stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready.
REQ-018 When the ready pulse for one requester coincides with a request from the other, that request SHALL be granted from the following IDLE cycle, subject to REQ-006/007.

Reset
REQ-019 When rst_n=0 at an edge, the block SHALL enter IDLE regardless of state, and SHALL set to 0: counter, starve_cnt, gnt_src, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready.
REQ-020 A reset during BUSY SHALL abort the access with no ready pulse; the first grant SHALL be possible on the first edge with rst_n=1.

Structure
REQ-021 The FSM state encoding, the MEM_LAT/STARVE_MAX defaults and the gnt_src encoding SHALL live in the shared package mem_arb_pkg.
REQ-022 The latency countdown SHALL be one sub-module, mem_lat_counter (load, decrement, zero flag).

Verification
REQ-023 Single fetch, MEM_LAT=2, if_addr=0x0000_0040, memory returns 0x2008_0005:
- mem_en high 2 cycles;
- if_ready pulses once;
- if_rdata=0x2008_0005;
- stall_if=1 until that ready cycle.
REQ-024 Simultaneous requests, dm_we=0, dm_addr=0x100 -> data is granted first; dm_ready precedes if_ready by MEM_LAT+2 cycles.
REQ-025 Store dm_addr=0x104, dm_wdata=0xDEAD_BEEF:
- mem_we=1 for MEM_LAT cycles with the stable address and data;
- dm_ready pulses;
- dm_rdata unchanged.
REQ-026 Starvation, STARVE_MAX=3, dm_req held high, if_req held high -> grant order D, D, D, I, D, ...
REQ-027 rst_n=0 during the 2nd BUSY cycle:
- next cycle: all outputs 0, IDLE, no ready pulse;
- after release with req held: a fresh full MEM_LAT access completes.
REQ-028 MEM_LAT=1 and MEM_LAT=15 back-to-back fetches -> ready spacing exactly 3 and 17 cycles respectively.
